// File: rtl/odometer_pkg.sv
// Shared types and constants for the odometer measurement sequencer.
package odometer_pkg;

  localparam int BF_W  = 12;
  localparam int TMO_W = 16;
  localparam logic [BF_W-1:0] DEADZONE_CODE = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_TRIG    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RELEASE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  function automatic logic is_deadzone(input logic [BF_W-1:0] value);
    return (value == DEADZONE_CODE);
  endfunction

endpackage

// File: rtl/odometer_sync2.sv
// Two-flop synchronizer bank for asynchronous status inputs.
module odometer_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {W{1'b0}};
      q    <= {W{1'b0}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/odometer_meas_sequencer.sv
// Sequences stacked odometer channels: stress, trigger, wait for done, capture count.
// Define ODO_AVG_EN to take four samples per channel and report their average.
module odometer_meas_sequencer
  import odometer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   CLK,
  input  logic                   RESETB,
  input  logic                   START,
  input  logic [NUM_CH-1:0]      CH_MASK,
  input  logic [NUM_CH-1:0]      MEAS_DONE,
  input  logic [BF_W*NUM_CH-1:0] BF_COUNTER_IN,
  output logic [NUM_CH-1:0]      MEAS_STRESS,
  output logic [NUM_CH-1:0]      MEAS_TRIG,
  output logic                   BUSY,
  output logic [BF_W-1:0]        RESULT,
  output logic [CH_W-1:0]        RESULT_CH,
  output logic                   RESULT_VALID,
  output logic                   RESULT_DEADZONE,
  output logic                   RESULT_TIMEOUT,
  output logic                   SWEEP_DONE
);

  localparam logic [TMO_W-1:0] CNT_ZERO    = TMO_W'(0);
  localparam logic [TMO_W-1:0] CNT_ONE     = TMO_W'(1);
  localparam logic [TMO_W-1:0] SETTLE_LAST = TMO_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      r = m[i] ? CH_W'(i) : r;
    end
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = {NUM_CH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [NUM_CH-1:0] done_sync;

  odometer_sync2 #(.W(NUM_CH)) u_done_sync (
    .clk   (CLK),
    .rst_n (RESETB),
    .d     (MEAS_DONE),
    .q     (done_sync)
  );

  state_t            state, state_nx;
  logic [CH_W-1:0]   ch, ch_nx;
  logic [NUM_CH-1:0] mask, mask_nx, mask_rem;
  logic [TMO_W-1:0]  cnt, cnt_nx;
  logic              tmo, tmo_nx;
  logic              done_s;
  logic [BF_W-1:0]   bf_sel, sample;

  logic [NUM_CH-1:0] stress_nx, trig_nx;
  logic              busy_nx, valid_nx, dz_nx, to_nx, sweep_done_nx;
  logic [BF_W-1:0]   result_nx;
  logic [CH_W-1:0]   result_ch_nx;

`ifdef ODO_AVG_EN
  logic [1:0]        smp, smp_nx;
  logic [BF_W+1:0]   acc, acc_nx;
  logic              dz_acc, dz_acc_nx, tmo_acc, tmo_acc_nx;
`endif

  assign done_s   = done_sync[ch];
  assign bf_sel   = BF_COUNTER_IN[int'(ch)*BF_W +: BF_W];
  // a timed-out measurement reports zero regardless of the counter bus
  assign sample   = tmo ? {BF_W{1'b0}} : bf_sel;
  assign mask_rem = mask & ~ch_onehot(ch);

  // FSM state register
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_nx      = state;
    ch_nx         = ch;
    mask_nx       = mask;
    cnt_nx        = cnt;
    tmo_nx        = tmo;
    result_nx     = RESULT;
    result_ch_nx  = RESULT_CH;
    dz_nx         = RESULT_DEADZONE;
    to_nx         = RESULT_TIMEOUT;
    valid_nx      = 1'b0;
    sweep_done_nx = 1'b0;
`ifdef ODO_AVG_EN
    smp_nx     = smp;
    acc_nx     = acc;
    dz_acc_nx  = dz_acc;
    tmo_acc_nx = tmo_acc;
`endif
    case (state)
      ST_IDLE: begin
        if (START && !BUSY) begin
          mask_nx = CH_MASK;
          cnt_nx  = CNT_ZERO;
          tmo_nx  = 1'b0;
`ifdef ODO_AVG_EN
          smp_nx     = 2'd0;
          acc_nx     = {(BF_W+2){1'b0}};
          dz_acc_nx  = 1'b0;
          tmo_acc_nx = 1'b0;
`endif
          if (CH_MASK == {NUM_CH{1'b0}}) begin
            state_nx = ST_FINISH;
          end else begin
            ch_nx    = lowest_ch(CH_MASK);
            state_nx = ST_ARM;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx   = CNT_ZERO;
          state_nx = ST_TRIG;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_TRIG: begin
        // done has priority over a simultaneous timeout
        if (done_s) begin
          cnt_nx   = CNT_ZERO;
          tmo_nx   = 1'b0;
          state_nx = ST_CAPTURE;
        end else if (cnt == TMO_LAST) begin
          cnt_nx   = CNT_ZERO;
          tmo_nx   = 1'b1;
          state_nx = ST_CAPTURE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (cnt == CNT_ONE) begin
          cnt_nx   = CNT_ZERO;
          state_nx = ST_RELEASE;
`ifdef ODO_AVG_EN
          acc_nx     = acc + {2'b00, sample};
          dz_acc_nx  = dz_acc | is_deadzone(sample);
          tmo_acc_nx = tmo_acc | tmo;
          if (smp == 2'd3) begin
            result_nx    = acc_nx[BF_W+1:2];
            result_ch_nx = ch;
            dz_nx        = dz_acc_nx;
            to_nx        = tmo_acc_nx;
            valid_nx     = 1'b1;
          end else begin
            valid_nx = 1'b0;
          end
`else
          result_nx    = sample;
          result_ch_nx = ch;
          dz_nx        = is_deadzone(sample);
          to_nx        = tmo;
          valid_nx     = 1'b1;
`endif
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!done_s || (cnt == TMO_LAST)) begin
          cnt_nx = CNT_ZERO;
          tmo_nx = 1'b0;
`ifdef ODO_AVG_EN
          if (smp == 2'd3) begin
            state_nx = ST_NEXT;
          end else begin
            smp_nx   = smp + 2'd1;
            state_nx = ST_ARM;
          end
`else
          state_nx = ST_NEXT;
`endif
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_NEXT: begin
        mask_nx = mask_rem;
`ifdef ODO_AVG_EN
        smp_nx     = 2'd0;
        acc_nx     = {(BF_W+2){1'b0}};
        dz_acc_nx  = 1'b0;
        tmo_acc_nx = 1'b0;
`endif
        if (mask_rem == {NUM_CH{1'b0}}) begin
          state_nx = ST_FINISH;
        end else begin
          ch_nx    = lowest_ch(mask_rem);
          state_nx = ST_ARM;
        end
      end
      ST_FINISH: begin
        sweep_done_nx = 1'b1;
        state_nx      = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // channel drives are registered from the next state so they track it with no extra cycle
    stress_nx = ((state_nx == ST_ARM) || (state_nx == ST_TRIG) || (state_nx == ST_CAPTURE))
                ? ch_onehot(ch_nx) : {NUM_CH{1'b0}};
    trig_nx   = ((state_nx == ST_TRIG) || (state_nx == ST_CAPTURE))
                ? ch_onehot(ch_nx) : {NUM_CH{1'b0}};
    busy_nx   = (state_nx != ST_IDLE) || (state == ST_FINISH);
  end

  // datapath and output registers
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ch              <= {CH_W{1'b0}};
      mask            <= {NUM_CH{1'b0}};
      cnt             <= CNT_ZERO;
      tmo             <= 1'b0;
      MEAS_STRESS     <= {NUM_CH{1'b0}};
      MEAS_TRIG       <= {NUM_CH{1'b0}};
      BUSY            <= 1'b0;
      RESULT          <= {BF_W{1'b0}};
      RESULT_CH       <= {CH_W{1'b0}};
      RESULT_VALID    <= 1'b0;
      RESULT_DEADZONE <= 1'b0;
      RESULT_TIMEOUT  <= 1'b0;
      SWEEP_DONE      <= 1'b0;
`ifdef ODO_AVG_EN
      smp             <= 2'd0;
      acc             <= {(BF_W+2){1'b0}};
      dz_acc          <= 1'b0;
      tmo_acc         <= 1'b0;
`endif
    end else begin
      ch              <= ch_nx;
      mask            <= mask_nx;
      cnt             <= cnt_nx;
      tmo             <= tmo_nx;
      MEAS_STRESS     <= stress_nx;
      MEAS_TRIG       <= trig_nx;
      BUSY            <= busy_nx;
      RESULT          <= result_nx;
      RESULT_CH       <= result_ch_nx;
      RESULT_VALID    <= valid_nx;
      RESULT_DEADZONE <= dz_nx;
      RESULT_TIMEOUT  <= to_nx;
      SWEEP_DONE      <= sweep_done_nx;
`ifdef ODO_AVG_EN
      smp             <= smp_nx;
      acc             <= acc_nx;
      dz_acc          <= dz_acc_nx;
      tmo_acc         <= tmo_acc_nx;
`endif
    end
  end

endmodule

// File: doc/odometer_meas_sequencer.md
Name: odometer_meas_sequencer

Overview:
- Digital-clock-domain controller that sequences NUM_CH stacked odometer measurement channels one at a time.
- Per channel it drives MEAS_STRESS/MEAS_TRIG, waits for the asynchronous MEAS_DONE, captures the 12-bit BF_COUNTER and publishes one result record.
- Sits between the scan/config register file and the odometer_meas_detect_stacked instances.
- Guards each measurement with a timeout and flags deadzone results.

Parameters:
- NUM_CH, 4, number of odometer channels (2..16)
- CH_W, 2, channel index width; equals clog2(NUM_CH)
- SETTLE_CYC, 8, CLK cycles MEAS_STRESS is held high before MEAS_TRIG rises
- TIMEOUT_CYC, 65535, CLK cycles to wait for MEAS_DONE before aborting (16-bit counter)

Ports:
- CLK  in  1  controller clock
- RESETB  in  1  asynchronous active-low reset
- START  in  1  single-cycle pulse that begins a sweep over the enabled channels
- CH_MASK  in  NUM_CH  channel enable bits; sampled on START
- MEAS_DONE  in  NUM_CH  per-channel done flags (asynchronous)
- BF_COUNTER_IN  in  12*NUM_CH  per-channel beat-frequency counts; channel k occupies bits [12k+11:12k]
- MEAS_STRESS  out  NUM_CH  per-channel stress-measure enable; at most one bit high
- MEAS_TRIG  out  NUM_CH  per-channel trigger; at most one bit high
- BUSY  out  1  high from the cycle after an accepted START through SWEEP_DONE
- RESULT  out  12  captured count
- RESULT_CH  out  CH_W  channel index of RESULT
- RESULT_VALID  out  1  single-cycle strobe that qualifies RESULT, RESULT_CH and the flags
- RESULT_DEADZONE  out  1  captured count equals 0xFFF
- RESULT_TIMEOUT  out  1  MEAS_DONE was not seen within TIMEOUT_CYC
- SWEEP_DONE  out  1  single-cycle pulse at the end of a sweep

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, mask register 0.
- RESETB asserted mid-operation drops MEAS_STRESS/MEAS_TRIG immediately (asynchronous); no RESULT_VALID is issued.
- MEAS_DONE passes through a 2-flop synchronizer per channel. Only the selected channel's synchronized bit (done_s) is used.
- FSM states:
  - IDLE: on START, latch CH_MASK; BUSY=1.
    - Latched mask == 0: go to FINISH.
    - Otherwise: ch = lowest set bit, go to ARM.
    - START received while BUSY is ignored.
  - ARM: MEAS_STRESS[ch]=1; stay SETTLE_CYC cycles, then go to TRIG.
  - TRIG: MEAS_TRIG[ch]=1; timeout counter increments each cycle.
    - done_s=1: go to CAPTURE.
    - Counter reaches TIMEOUT_CYC-1 with done_s=0: go to CAPTURE with tmo=1.
    - done_s and timeout in the same cycle: done wins, tmo=0.
  - CAPTURE: two-cycle wait (BF_COUNTER_IN is quasi-static after done), then register BF_COUNTER_IN[ch].
    - tmo=1: RESULT=0, RESULT_TIMEOUT=1.
    - Otherwise: RESULT_DEADZONE = (RESULT==12'hFFF).
    - Pulse RESULT_VALID for one cycle, then go to RELEASE.
  - RELEASE: MEAS_TRIG[ch]=0 and MEAS_STRESS[ch]=0; wait until done_s=0 (bounded by the same timeout), then go to NEXT.
  - NEXT: clear the mask bit for ch.
    - Remaining mask == 0: go to FINISH.
    - Otherwise: ch = next lowest set bit, go to ARM.
  - FINISH: SWEEP_DONE=1 for one cycle, BUSY=0, go to IDLE.
- Outputs are registered. RESULT, RESULT_CH and the flags hold their values until the next RESULT_VALID.
- Latency: START to first MEAS_STRESS edge is 1 cycle. The mask==0 case gives SWEEP_DONE 2 cycles after START.
- Channel walk is ascending; channels are never revisited within one sweep.

Optional Feature:
- ODO_AVG_EN defined: each enabled channel is measured 4 times back to back (ARM..RELEASE loop).
  - The four 12-bit counts are summed into a 14-bit accumulator; RESULT = sum[13:2].
  - One RESULT_VALID is issued per channel.
  - RESULT_DEADZONE is set if any sample was 0xFFF; RESULT_TIMEOUT is set if any sample timed out (a timed-out sample contributes 0).
- Not defined: single sample per channel, and no accumulator is synthesized.

Decomposition:
- Shared package odometer_pkg:
  - FSM state encoding (IDLE, ARM, TRIG, CAPTURE, RELEASE, NEXT, FINISH)
  - BF_W=12 and DEADZONE_CODE=12'hFFF
  - TMO_W=16
- One sub-module: odometer_sync2, a parameterised-width 2-flop synchronizer with async active-low reset. It is instantiated once for MEAS_DONE.

Test Plan:
- Basic order: CH_MASK=4'b1011, each channel model returns done after 50 cycles with counts 0x123/0x456/-/0xABC. Required: three RESULT_VALID strobes with RESULT_CH 0,1,3 carrying matching counts, then SWEEP_DONE, and MEAS_STRESS[2] never high.
- Deadzone: channel 0 returns 0xFFF. Required: RESULT_DEADZONE=1, RESULT_TIMEOUT=0.
- Timeout: TIMEOUT_CYC=100, channel 1 never asserts done. Required: RESULT_VALID with RESULT=0 and RESULT_TIMEOUT=1 about 100 cycles after MEAS_TRIG[1] rises; the sweep continues to the next channel.
- Edge cases:
  - CH_MASK=0 then START: SWEEP_DONE 2 cycles later, no RESULT_VALID, no MEAS_STRESS activity.
  - A second START while BUSY: ignored.
- Reset mid-TRIG: RESETB low for 3 cycles. Required: all outputs 0 asynchronously and the FSM in IDLE; a following START produces a clean sweep.
- ODO_AVG_EN: samples 100, 101, 102, 105. Required: RESULT=102 (sum 408>>2); a single 0xFFF sample sets RESULT_DEADZONE.
